// File: rtl/bicubic_pkg.sv
// Shared constants and types for the bicubic upsample scheduler.
// Optional build macro used by this slice: BICUBIC_SCHED_FIXED_PRIO_EN
// (fixed-priority arbitration instead of round-robin).
package bicubic_pkg;

  localparam int unsigned CHANNEL_WIDTH = 8;
  localparam int unsigned BEATS         = 16;
  localparam int unsigned WINDOW_WIDTH  = 16 * CHANNEL_WIDTH;
  localparam int unsigned IDX_WIDTH     = 4;
  localparam int unsigned CHAN_WIDTH    = 2;

  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } state_e;

endpackage

// File: rtl/bicubic_rr_arbiter.sv
// Combinational one-hot arbiter for the window scheduler.
// Default: round-robin, search starts at ptr. With BICUBIC_SCHED_FIXED_PRIO_EN
// defined: fixed priority, lowest index wins and ptr is ignored.
// Ports: req (request vector), ptr (round-robin start), grant (one-hot or zero).
module bicubic_rr_arbiter #(
  parameter int unsigned NUM_REQ = 3
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [1:0]         ptr,
  output logic [NUM_REQ-1:0] grant
);

`ifdef BICUBIC_SCHED_FIXED_PRIO_EN
  logic unused_ptr;
  assign unused_ptr = ^ptr;

  // Isolate the lowest set request bit.
  assign grant = req & (~req + NUM_REQ'(1));
`else
  logic [2*NUM_REQ-1:0] req_dbl;
  logic [2*NUM_REQ-1:0] gnt_dbl;
  logic [NUM_REQ-1:0]   req_rot;
  logic [NUM_REQ-1:0]   gnt_rot;

  // Rotate so ptr sits at bit 0, pick the lowest bit, rotate back.
  assign req_dbl = {req, req} >> ptr;
  assign req_rot = req_dbl[NUM_REQ-1:0];
  assign gnt_rot = req_rot & (~req_rot + NUM_REQ'(1));
  assign gnt_dbl = {gnt_rot, gnt_rot} << ptr;
  assign grant   = gnt_dbl[2*NUM_REQ-1:NUM_REQ];
`endif

endmodule

// File: rtl/dfflr.sv
// Generic load-enable flop with asynchronous active-low reset to zero.
// Ports: clk, rst_n, en (load), d (next value), q (registered value).
module dfflr #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  q <= '0;
    else if (en) q <= d;
  end

endmodule

// File: rtl/dffr.sv
// Generic flop with asynchronous active-low reset to zero.
// Ports: clk, rst_n, d (next value), q (registered value).
module dffr #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) q <= '0;
    else        q <= d;
  end

endmodule

// File: rtl/bicubic_upsample_sched.sv
// Shares one 16-phase bicubic upsample engine among NUM_REQ channel requesters.
// A granted 4x4 window is registered onto eng_pix and held while the engine
// streams its 16 phases; each phase is forwarded with channel, index and last.
// Build option: BICUBIC_SCHED_FIXED_PRIO_EN selects fixed-priority arbitration.
// Ports:
//   req_valid/req_ready/req_window : per-requester window offer (ready one-hot)
//   eng_req_valid/eng_req_ready    : window valid to engine / engine in phase 0
//   eng_pix                        : registered window p1..p16
//   eng_rsp_*                      : engine output stream
//   out_*                          : downstream pixel stream with tags
module bicubic_upsample_sched
  import bicubic_pkg::*;
#(
  parameter int unsigned NUM_REQ = 3
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [NUM_REQ-1:0]                req_valid,
  output logic [NUM_REQ-1:0]                req_ready,
  input  logic [NUM_REQ*WINDOW_WIDTH-1:0]   req_window,
  output logic                              eng_req_valid,
  input  logic                              eng_req_ready,
  output logic [WINDOW_WIDTH-1:0]           eng_pix,
  input  logic [CHANNEL_WIDTH-1:0]          eng_rsp_data,
  input  logic                              eng_rsp_valid,
  output logic                              eng_rsp_ready,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [CHANNEL_WIDTH-1:0]          out_data,
  output logic [CHAN_WIDTH-1:0]             out_chan,
  output logic [IDX_WIDTH-1:0]              out_idx,
  output logic                              out_last
);

  state_e                  state_q;
  state_e                  state_d;
  logic                    state_raw;
  logic                    in_stream;
  logic                    in_idle;
  logic [IDX_WIDTH-1:0]    cnt_q;
  logic [IDX_WIDTH-1:0]    cnt_d;
  logic                    cnt_en;
  logic [NUM_REQ-1:0]      grant;
  logic [1:0]              ptr_q;
  logic                    req_hs;
  logic                    beat_hs;
  logic                    last_beat;
  logic [WINDOW_WIDTH-1:0] win_acc [NUM_REQ+1];
  logic [CHAN_WIDTH-1:0]   idx_acc [NUM_REQ+1];

  // The engine realigns to phase 0 through the shared reset, so its ready is
  // informational only.
  logic unused_eng_req_ready;
  assign unused_eng_req_ready = eng_req_ready;

  dffr #(.WIDTH(1)) u_state (.clk(clk), .rst_n(rst_n), .d(state_d), .q(state_raw));
  assign state_q   = state_e'(state_raw);
  assign in_stream = (state_q == STREAM);
  assign in_idle   = ~in_stream;

  bicubic_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .req   (req_valid & {NUM_REQ{in_idle}}),
    .ptr   (ptr_q),
    .grant (grant)
  );

  // req_ready is held low while reset is asserted, even with requests pending.
  assign req_ready = (in_idle && rst_n) ? grant : '0;
  assign req_hs    = |req_ready;
  assign beat_hs   = in_stream & eng_rsp_valid & out_ready;
  assign last_beat = (cnt_q == IDX_WIDTH'(BEATS - 1));

  // AND-OR select of the winner's window and index.
  assign win_acc[0] = '0;
  assign idx_acc[0] = '0;
  for (genvar g = 0; g < NUM_REQ; g++) begin : g_sel
    assign win_acc[g+1] = win_acc[g]
                        | ({WINDOW_WIDTH{grant[g]}} & req_window[g*WINDOW_WIDTH +: WINDOW_WIDTH]);
    assign idx_acc[g+1] = idx_acc[g] | (grant[g] ? CHAN_WIDTH'(g) : '0);
  end

  // Next-state and beat counter control.
  always_comb begin
    state_d = state_q;
    cnt_en  = 1'b0;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (req_hs) begin
          state_d = STREAM;
          cnt_en  = 1'b1;
          cnt_d   = '0;
        end
      end
      STREAM: begin
        if (beat_hs) begin
          cnt_en = 1'b1;
          cnt_d  = cnt_q + IDX_WIDTH'(1);
          if (last_beat) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  dfflr #(.WIDTH(IDX_WIDTH)) u_cnt (
    .clk(clk), .rst_n(rst_n), .en(cnt_en), .d(cnt_d), .q(cnt_q)
  );

  dfflr #(.WIDTH(WINDOW_WIDTH)) u_win (
    .clk(clk), .rst_n(rst_n), .en(req_hs), .d(win_acc[NUM_REQ]), .q(eng_pix)
  );

  dfflr #(.WIDTH(CHAN_WIDTH)) u_chan (
    .clk(clk), .rst_n(rst_n), .en(req_hs), .d(idx_acc[NUM_REQ]), .q(out_chan)
  );

`ifdef BICUBIC_SCHED_FIXED_PRIO_EN
  assign ptr_q = '0;
`else
  // After a completed burst, the next search starts just past its owner.
  logic [1:0] ptr_d;
  assign ptr_d = (out_chan == 2'(NUM_REQ - 1)) ? 2'b0 : out_chan + 2'd1;

  dfflr #(.WIDTH(2)) u_ptr (
    .clk(clk), .rst_n(rst_n), .en(beat_hs & last_beat), .d(ptr_d), .q(ptr_q)
  );
`endif

  // Engine-to-downstream path is combinational and only open in STREAM.
  assign eng_req_valid = in_stream;
  assign eng_rsp_ready = in_stream & out_ready;
  assign out_valid     = in_stream & eng_rsp_valid;
  assign out_data      = in_stream ? eng_rsp_data : '0;
  assign out_idx       = cnt_q;
  assign out_last      = in_stream & last_beat;

endmodule

// File: tb/tb_bicubic_upsample_sched.sv
// Scoreboard bench for bicubic_upsample_sched: requesters and a pass-through
// engine stub are driven on the falling edge; a monitor samples just before
// each rising edge and compares against a queue of expected beats.
module tb_bicubic_upsample_sched;

  localparam int N = 3;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [N-1:0]     req_valid = '0;
  logic [N-1:0]     req_ready;
  logic [N*128-1:0] req_window = '0;
  logic             eng_req_valid;
  logic             eng_req_ready = 1'b1;
  logic [127:0]     eng_pix;
  logic [7:0]       eng_rsp_data = '0;
  logic             eng_rsp_valid = 1'b0;
  logic             eng_rsp_ready;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [7:0]       out_data;
  logic [1:0]       out_chan;
  logic [3:0]       out_idx;
  logic             out_last;

  always #5 clk = ~clk;

  bicubic_upsample_sched #(.NUM_REQ(N)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_window(req_window),
    .eng_req_valid(eng_req_valid), .eng_req_ready(eng_req_ready), .eng_pix(eng_pix),
    .eng_rsp_data(eng_rsp_data), .eng_rsp_valid(eng_rsp_valid), .eng_rsp_ready(eng_rsp_ready),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_chan(out_chan), .out_idx(out_idx), .out_last(out_last)
  );

  typedef struct {
    logic [7:0] data;
    logic [1:0] chan;
    logic [3:0] idx;
    logic       last;
  } beat_t;

  beat_t        exp_q[$];
  int           checks = 0;
  int           errors = 0;

  // reference model state
  logic [127:0] win_v [N];
  logic [127:0] cur_pix = '0;
  bit           busy = 0;
  int           ptr_m = 0;
  bit           acc [N];
  bit           eng_acc = 0;
  int           ph = 0;
  int           cyc = 0;
  int           last_grant = -1;
  bit           gap_chk = 0;

  // stimulus controls
  bit           want [N];
  bit           const_mode = 1;
  int           const_val [N];
  bit           full = 1;
  bit           ready_pat = 0;
  bit           err_inj = 0;
  int           pat_i = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Who should win among valid requesters, from the arbitration rule.
  function automatic int arb_model(input logic [N-1:0] v, input int p);
`ifdef BICUBIC_SCHED_FIXED_PRIO_EN
    for (int i = 0; i < N; i++) if (v[i]) return i;
`else
    for (int k = 0; k < N; k++) begin
      int r;
      r = (p + k) % N;
      if (v[r]) return r;
    end
`endif
    return -1;
  endfunction

  task automatic sample();
    logic [N-1:0] exp_rr;
    int           w;
    bit           was_busy;
    bit           bhs;
    beat_t        b;
    cyc++;
    was_busy = busy;
    bhs      = busy && eng_rsp_valid && out_ready;
    exp_rr   = '0;
    w        = -1;
    if (!busy) begin
      w = arb_model(req_valid, ptr_m);
      if (w >= 0) exp_rr[w] = 1'b1;
    end
    chk("req_ready", req_ready, exp_rr);
    chk("out_valid", out_valid, busy && eng_rsp_valid);
    chk("eng_req_valid", eng_req_valid, busy);
    chk("eng_rsp_ready", eng_rsp_ready, busy && out_ready);
    if (busy) chk("eng_pix", eng_pix, cur_pix);
    if (out_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL beat: got unexpected idx %0d expected no beat", out_idx);
      end else begin
        b = exp_q[0];
        chk("beat", {out_data, out_chan, out_idx, out_last}, {b.data, b.chan, b.idx, b.last});
        if (out_ready) begin
          void'(exp_q.pop_front());
          if (b.last) begin
            busy  = 0;
            ptr_m = (int'(b.chan) + 1) % N;
          end
        end
      end
    end
    if (bhs) eng_acc = 1;
    if (!was_busy && w >= 0 && req_ready[w]) begin
      acc[w]  = 1;
      cur_pix = win_v[w];
      busy    = 1;
      for (int k = 0; k < 16; k++) begin
        b.data = win_v[w][k*8 +: 8];
        b.chan = 2'(w);
        b.idx  = 4'(k);
        b.last = (k == 15);
        exp_q.push_back(b);
      end
      if (gap_chk) begin
        if (last_grant >= 0) chk("grant_gap", 128'(cyc - last_grant), 128'd17);
        last_grant = cyc;
      end
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      #4;
      if (rst_n) sample();
    end
  end

  // One falling-edge stimulus step: requesters, engine stub, downstream ready.
  task automatic step();
    @(negedge clk);
    for (int r = 0; r < N; r++) begin
      if (acc[r]) begin
        acc[r]       = 0;
        req_valid[r] = 1'b0;
      end
      if (!req_valid[r] && want[r] && (full || $urandom_range(0, 2) == 0)) begin
        if (const_mode) win_v[r] = {16{8'(const_val[r])}};
        else for (int k = 0; k < 16; k++) win_v[r][k*8 +: 8] = 8'($urandom);
        req_window[r*128 +: 128] = win_v[r];
        req_valid[r] = 1'b1;
      end
    end
    if (eng_acc) begin
      eng_acc = 0;
      ph      = (ph + 1) % 16;
    end
    eng_req_ready = (ph == 0);
    if (eng_req_valid) begin
      eng_rsp_valid = full ? 1'b1 : ($urandom_range(0, 3) != 0);
      eng_rsp_data  = eng_pix[ph*8 +: 8];
    end else begin
      eng_rsp_valid = err_inj && ($urandom_range(0, 3) == 0);
      eng_rsp_data  = 8'($urandom);
    end
    if (ready_pat) begin
      out_ready = (pat_i % 4 == 0) || (pat_i % 4 == 3);
      pat_i++;
    end else begin
      out_ready = full ? 1'b1 : ($urandom_range(0, 3) != 0);
    end
  endtask

  task automatic drain();
    bit ok;
    ok = 0;
    for (int r = 0; r < N; r++) want[r] = 0;
    for (int i = 0; i < 300 && !ok; i++) begin
      if (!busy && req_valid == '0) ok = 1;
      else step();
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL drain: got busy=%0d expected idle within 300 cycles", busy);
    end
  endtask

  task automatic set_const(input int a, input int b, input int c);
    const_mode   = 1;
    const_val[0] = a;
    const_val[1] = b;
    const_val[2] = c;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_out_valid"}, out_valid, 0);
    chk({tag, "_out_data"}, out_data, 0);
    chk({tag, "_out_chan"}, out_chan, 0);
    chk({tag, "_out_idx"}, out_idx, 0);
    chk({tag, "_out_last"}, out_last, 0);
    chk({tag, "_eng_req_valid"}, eng_req_valid, 0);
    chk({tag, "_eng_rsp_ready"}, eng_rsp_ready, 0);
    chk({tag, "_eng_pix"}, eng_pix, 0);
    chk({tag, "_req_ready"}, req_ready, 0);
  endtask

  initial begin
    bit hit;
    for (int r = 0; r < N; r++) begin
      want[r] = 0;
      acc[r]  = 0;
      win_v[r] = '0;
    end

    // power-on reset
    repeat (2) @(negedge clk);
    #1 chk_all_zero("rst");
    @(negedge clk);
    rst_n = 1'b1;

    // single requester R0, constant 100, full throughput
    set_const(100, 0, 0);
    full    = 1;
    want[0] = 1;
    repeat (40) step();
    drain();

    // all three continuously valid with distinct constants
    set_const(10, 20, 30);
    for (int r = 0; r < N; r++) want[r] = 1;
    last_grant = -1;
    gap_chk    = 1;
    repeat (110) step();
    gap_chk = 0;
    drain();

    // R2 alone with out_ready pattern 1,0,0,1
    set_const(0, 0, 60);
    want[2]   = 1;
    ready_pat = 1;
    pat_i     = 0;
    repeat (80) step();
    ready_pat = 0;
    drain();

    // random windows, random valid/ready, stray engine valids in IDLE
    const_mode = 0;
    full       = 0;
    err_inj    = 1;
    for (int r = 0; r < N; r++) want[r] = 1;
    repeat (1500) step();
    err_inj = 0;
    drain();

    // reset asserted while beat 7 is being presented
    full = 1;
    set_const(50, 77, 0);
    want[0] = 1;
    hit = 0;
    for (int i = 0; i < 100 && !hit; i++) begin
      step();
      if (busy && exp_q.size() == 9) hit = 1;
    end
    checks++;
    if (!hit) begin
      errors++;
      $display("FAIL reach_beat7: got no beat 7 expected one within 100 cycles");
    end
    #2 rst_n = 1'b0;
    #1 chk_all_zero("midrst");
    exp_q.delete();
    busy          = 0;
    ptr_m         = 0;
    ph            = 0;
    eng_acc       = 0;
    eng_rsp_valid = 1'b0;
    req_valid     = '0;
    last_grant    = -1;
    for (int r = 0; r < N; r++) begin
      acc[r]  = 0;
      want[r] = 0;
    end
    repeat (2) @(negedge clk);
    rst_n   = 1'b1;
    want[1] = 1;
    repeat (40) step();
    drain();

    chk("queue_empty", 128'(exp_q.size()), 128'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
